// File: rtl/exec_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// exec_wb_stage_pkg
// Shared definitions for the execute/writeback stage and its forwarding bus.
//   NUM_FUS    : number of functional units feeding the stage
//   XLEN       : result data width
//   REG_IDX_W  : architectural register index width
//   RR_W       : width of the round-robin scan pointer
//   wb_entry_t : one buffered result {dst, val}
// ---------------------------------------------------------------------------
package exec_wb_stage_pkg;
    localparam int NUM_FUS   = 4;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int RR_W      = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic [XLEN-1:0]      val;
    } wb_entry_t;
endpackage

// File: rtl/execute_fwrd_if.sv
// ---------------------------------------------------------------------------
// execute_fwrd_if
// One forwarding slot per functional unit.
//   ex_valid : slot carries a live result
//   dst_reg  : destination register of that result (0 when not valid)
//   ex_val   : result value (0 when not valid)
// Modports: exec (producer, drives all), fwd (forwarding unit, reads all).
// ---------------------------------------------------------------------------
interface execute_fwrd_if;
    logic                                    ex_valid;
    logic [exec_wb_stage_pkg::REG_IDX_W-1:0] dst_reg;
    logic [exec_wb_stage_pkg::XLEN-1:0]      ex_val;

    modport exec (output ex_valid, output dst_reg, output ex_val);
    modport fwd  (input  ex_valid, input  dst_reg, input  ex_val);
endinterface

// File: rtl/wb_result_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
// Small per-FU result queue with registered storage.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : empties the queue at the next edge (beats push and pop)
//   push     : enqueue wr_data (ignored when full)
//   pop      : dequeue head (ignored when empty)
//   wr_data  : entry to enqueue
//   head     : oldest entry (meaningless when empty)
//   empty    : no entries
//   full     : DEPTH entries
// ---------------------------------------------------------------------------
module wb_result_fifo
    import exec_wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wr_data,
    output wb_entry_t head,
    output logic      empty,
    output logic      full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: contents are only observed through a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/exec_wb_stage.sv
// ---------------------------------------------------------------------------
// exec_wb_stage
// Buffers FU results, broadcasts each queue head on its forwarding slot and
// drains the heads onto the register-file write ports round-robin.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : drop all buffered results, block pushes and writes this cycle
//   fu_valid  : per-FU result valid          fu_ready : per-FU accept
//   fu_dst    : per-FU destination register  fu_val   : per-FU result value
//   exec_if   : per-FU forwarding slot (ex_valid, dst_reg, ex_val)
//   wb_en     : per-port RF write enable
//   wb_idx    : per-port RF write index      wb_data  : per-port RF write data
// ---------------------------------------------------------------------------
module exec_wb_stage
    import exec_wb_stage_pkg::*;
#(
    parameter int NUM_WB_PORTS = 2,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [NUM_FUS-1:0]                     fu_valid,
    output logic [NUM_FUS-1:0]                     fu_ready,
    input  logic [NUM_FUS-1:0][REG_IDX_W-1:0]      fu_dst,
    input  logic [NUM_FUS-1:0][XLEN-1:0]           fu_val,
    execute_fwrd_if.exec                           exec_if [NUM_FUS],
    output logic [NUM_WB_PORTS-1:0]                wb_en,
    output logic [NUM_WB_PORTS-1:0][REG_IDX_W-1:0] wb_idx,
    output logic [NUM_WB_PORTS-1:0][XLEN-1:0]      wb_data
);
    wb_entry_t         fifo_head [NUM_FUS];
    logic [NUM_FUS-1:0] fifo_empty;
    logic [NUM_FUS-1:0] fifo_full;
    logic [NUM_FUS-1:0] fifo_pop;
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;

    int   ports_used;
    int   scan_idx;
    int   last_grant;
    logic any_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FUS; gi++) begin : g_fu
            wb_entry_t wr_entry;
            logic      fwd_valid;

            assign wr_entry     = '{dst: fu_dst[gi], val: fu_val[gi]};
            // No pop bypass: a full queue refuses even if its head leaves this cycle.
            assign fu_ready[gi] = !rst && !fifo_full[gi];

            wb_result_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .push    (fu_valid[gi] && fu_ready[gi]),
                .pop     (fifo_pop[gi]),
                .wr_data (wr_entry),
                .head    (fifo_head[gi]),
                .empty   (fifo_empty[gi]),
                .full    (fifo_full[gi])
            );

            // x0 results are never forwarded.
            assign fwd_valid              = !fifo_empty[gi] && (fifo_head[gi].dst != '0);
            assign exec_if[gi].ex_valid   = fwd_valid;
            assign exec_if[gi].dst_reg    = fwd_valid ? fifo_head[gi].dst : '0;
            assign exec_if[gi].ex_val     = fwd_valid ? fifo_head[gi].val : '0;
        end
    endgenerate

    // Cyclic scan starting at rr_ptr: x0 heads are discarded without a port,
    // the first NUM_WB_PORTS real heads take ports in scan order.
    always_comb begin
        fifo_pop   = '0;
        wb_en      = '0;
        wb_idx     = '0;
        wb_data    = '0;
        ports_used = 0;
        scan_idx   = 0;
        last_grant = 0;
        any_grant  = 1'b0;
        for (int k = 0; k < NUM_FUS; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_FUS) scan_idx = scan_idx - NUM_FUS;
            if (!fifo_empty[scan_idx]) begin
                if (fifo_head[scan_idx].dst == '0) begin
                    fifo_pop[scan_idx] = 1'b1;
                end else if (ports_used < NUM_WB_PORTS) begin
                    fifo_pop[scan_idx]  = 1'b1;
                    wb_en[ports_used]   = 1'b1;
                    wb_idx[ports_used]  = fifo_head[scan_idx].dst;
                    wb_data[ports_used] = fifo_head[scan_idx].val;
                    ports_used          = ports_used + 1;
                    last_grant          = scan_idx;
                    any_grant           = 1'b1;
                end
            end
        end

        if (flush) begin
            wb_en   = '0;
            wb_idx  = '0;
            wb_data = '0;
        end

        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (any_grant) begin
            rr_ptr_d = (last_grant == NUM_FUS - 1) ? '0 : RR_W'(last_grant + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: tb/tb_exec_wb_stage.sv
module tb_exec_wb_stage;
    import exec_wb_stage_pkg::*;

    localparam int NP = 2;
    localparam int D  = 2;
    localparam int EW = REG_IDX_W + XLEN;

    typedef logic [NUM_FUS-1:0][REG_IDX_W-1:0] dst_vec_t;
    typedef logic [NUM_FUS-1:0][XLEN-1:0]      val_vec_t;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            flush = 1'b0;
    logic [NUM_FUS-1:0]              fu_valid = '0;
    logic [NUM_FUS-1:0]              fu_ready;
    dst_vec_t                        fu_dst = '0;
    val_vec_t                        fu_val = '0;
    logic [NP-1:0]                   wb_en;
    logic [NP-1:0][REG_IDX_W-1:0]    wb_idx;
    logic [NP-1:0][XLEN-1:0]         wb_data;

    execute_fwrd_if exec_if [NUM_FUS] ();

    logic [NUM_FUS-1:0] exv_w;
    dst_vec_t           dreg_w;
    val_vec_t           exval_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FUS; gi++) begin : g_tap
            assign exv_w[gi]   = exec_if[gi].ex_valid;
            assign dreg_w[gi]  = exec_if[gi].dst_reg;
            assign exval_w[gi] = exec_if[gi].ex_val;
        end
    endgenerate

    exec_wb_stage #(
        .NUM_WB_PORTS (NP),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .fu_valid (fu_valid),
        .fu_ready (fu_ready),
        .fu_dst   (fu_dst),
        .fu_val   (fu_val),
        .exec_if  (exec_if),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: one queue of {dst,val} per FU and a scan start index.
    logic [EW-1:0]      mq [NUM_FUS][$];
    int                 rr_m = 0;
    logic [NUM_FUS-1:0] exp_ready;

    // FU-side holding registers for the randomized producers.
    logic [NUM_FUS-1:0] pend_v = '0;
    dst_vec_t           pend_d = '0;
    val_vec_t           pend_x = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_FUS; i++) mq[i].delete();
        rr_m = 0;
    endtask

    // One cycle: apply inputs, compare DUT against the model before the edge,
    // then advance the model across the edge.
    task automatic step(input logic [NUM_FUS-1:0] v, input dst_vec_t d, input val_vec_t x,
                        input logic fl);
        logic [NP-1:0]                e_en;
        logic [NP-1:0][REG_IDX_W-1:0] e_idx;
        logic [NP-1:0][XLEN-1:0]      e_data;
        logic [NUM_FUS-1:0]           pop;
        logic [EW-1:0]                ent;
        logic [REG_IDX_W-1:0]         hd;
        logic [XLEN-1:0]              hv;
        int                           used;
        int                           f;
        int                           last;

        fu_valid = v;
        fu_dst   = d;
        fu_val   = x;
        flush    = fl;
        @(negedge clk);

        e_en = '0; e_idx = '0; e_data = '0; pop = '0; used = 0; last = -1;
        for (int i = 0; i < NUM_FUS; i++) begin
            exp_ready[i] = (mq[i].size() < D);
            hd = '0; hv = '0;
            if (mq[i].size() > 0) begin
                ent = mq[i][0];
                if (ent[EW-1:XLEN] != '0) begin
                    hd = ent[EW-1:XLEN];
                    hv = ent[XLEN-1:0];
                end
            end
            check($sformatf("c%0d ex_valid[%0d]", cyc, i), 64'(exv_w[i]), 64'(hd != '0));
            check($sformatf("c%0d dst_reg[%0d]", cyc, i), 64'(dreg_w[i]), 64'(hd));
            check($sformatf("c%0d ex_val[%0d]", cyc, i), 64'(exval_w[i]), 64'(hv));
        end
        for (int k = 0; k < NUM_FUS; k++) begin
            f = (rr_m + k) % NUM_FUS;
            if (mq[f].size() > 0) begin
                ent = mq[f][0];
                if (ent[EW-1:XLEN] == '0) begin
                    pop[f] = 1'b1;
                end else if (used < NP) begin
                    e_en[used]   = 1'b1;
                    e_idx[used]  = ent[EW-1:XLEN];
                    e_data[used] = ent[XLEN-1:0];
                    pop[f]       = 1'b1;
                    last         = f;
                    used++;
                end
            end
        end
        if (fl) begin
            e_en = '0; e_idx = '0; e_data = '0;
        end
        check($sformatf("c%0d fu_ready", cyc), 64'(fu_ready), 64'(exp_ready));
        check($sformatf("c%0d wb_en", cyc), 64'(wb_en), 64'(e_en));
        for (int p = 0; p < NP; p++) begin
            check($sformatf("c%0d wb_idx[%0d]", cyc, p), 64'(wb_idx[p]), 64'(e_idx[p]));
            check($sformatf("c%0d wb_data[%0d]", cyc, p), 64'(wb_data[p]), 64'(e_data[p]));
        end
        $display("cyc %0d valid=%b flush=%b ready=%b ex_valid=%b wb_en=%b idx0=%0d idx1=%0d",
                 cyc, v, fl, fu_ready, exv_w, wb_en, wb_idx[0], wb_idx[1]);

        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            for (int i = 0; i < NUM_FUS; i++) if (pop[i]) void'(mq[i].pop_front());
            if (last >= 0) rr_m = (last + 1) % NUM_FUS;
            for (int i = 0; i < NUM_FUS; i++)
                if (v[i] && exp_ready[i]) mq[i].push_back({d[i], x[i]});
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0);
    endtask

    task automatic rand_step(input logic allow_flush);
        logic fl;
        for (int i = 0; i < NUM_FUS; i++) begin
            if (!pend_v[i] && ($urandom_range(0, 2) != 0)) begin
                pend_v[i] = 1'b1;
                pend_d[i] = ($urandom_range(0, 4) == 0) ? '0 : REG_IDX_W'($urandom_range(1, 31));
                pend_x[i] = $urandom;
            end
        end
        fl = allow_flush && ($urandom_range(0, 24) == 0);
        step(pend_v, pend_d, pend_x, fl);
        // Accepted results retire from the producer; refused ones are held.
        for (int i = 0; i < NUM_FUS; i++)
            if (pend_v[i] && exp_ready[i] && !fl) pend_v[i] = 1'b0;
    endtask

    initial begin
        dst_vec_t d;
        val_vec_t x;
        logic [XLEN-1:0] t4_vals [3];

        // Reset state, with a producer already asserting valid.
        fu_valid = '1;
        #2;
        check("rst fu_ready", 64'(fu_ready), 64'(0));
        check("rst wb_en", 64'(wb_en), 64'(0));
        check("rst ex_valid", 64'(exv_w), 64'(0));
        check("rst wb_data0", 64'(wb_data[0]), 64'(0));
        fu_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_clear();

        // Test 1: single result through FU0.
        d = '0; x = '0; d[0] = 5'd5; x[0] = 32'hDEAD;
        step(4'b0001, d, x, 1'b0);
        fu_valid = '0; #1;
        check("t1 ex_valid0", 64'(exv_w[0]), 64'(1));
        check("t1 dst_reg0", 64'(dreg_w[0]), 64'(5));
        check("t1 wb_en", 64'(wb_en), 64'(2'b01));
        check("t1 wb_idx0", 64'(wb_idx[0]), 64'(5));
        check("t1 wb_data0", 64'(wb_data[0]), 64'(32'hDEAD));
        idle();
        check("t1 empty after", 64'(exv_w[0]), 64'(0));

        // Flush clears rr so test 2 starts at FU0.
        step('0, '0, '0, 1'b1);

        // Test 2: four results in one cycle, two ports.
        for (int i = 0; i < NUM_FUS; i++) begin
            d[i] = REG_IDX_W'(i + 1);
            x[i] = 32'h1000 + 32'(i);
        end
        step(4'b1111, d, x, 1'b0);
        fu_valid = '0; #1;
        check("t2 wb_en a", 64'(wb_en), 64'(2'b11));
        check("t2 wb_idx0 a", 64'(wb_idx[0]), 64'(1));
        check("t2 wb_idx1 a", 64'(wb_idx[1]), 64'(2));
        idle();
        check("t2 wb_idx0 b", 64'(wb_idx[0]), 64'(3));
        check("t2 wb_idx1 b", 64'(wb_idx[1]), 64'(4));
        check("t2 wb_data1 b", 64'(wb_data[1]), 64'(32'h1003));
        idle();

        // Test 3: x0 result on FU1 is dropped silently.
        d = '0; x = '0; x[1] = 32'h5555;
        step(4'b0010, d, x, 1'b0);
        fu_valid = '0; #1;
        check("t3 ex_valid1", 64'(exv_w[1]), 64'(0));
        check("t3 wb_en", 64'(wb_en), 64'(0));
        idle();
        idle();

        // Test 4: FU2 sends three results while FU0/FU1 keep the ports busy.
        t4_vals[0] = 32'hA0; t4_vals[1] = 32'hA1; t4_vals[2] = 32'hA2;
        pend_v = '0;
        begin
            int n2;
            n2 = 0;
            for (int c = 0; c < 8; c++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!pend_v[i] && c < 5) begin
                        pend_v[i] = 1'b1;
                        pend_d[i] = REG_IDX_W'(10 + i);
                        pend_x[i] = 32'(c * 16 + i);
                    end
                end
                if (!pend_v[2] && n2 < 3) begin
                    pend_v[2] = 1'b1;
                    pend_d[2] = 5'd20;
                    pend_x[2] = t4_vals[n2];
                    n2++;
                end
                pend_v[3] = 1'b0;
                step(pend_v, pend_d, pend_x, 1'b0);
                for (int i = 0; i < NUM_FUS; i++)
                    if (pend_v[i] && exp_ready[i]) pend_v[i] = 1'b0;
            end
        end
        repeat (3) idle();

        // Test 5: load five entries, then flush with every FU pushing.
        for (int i = 0; i < NUM_FUS; i++) begin
            d[i] = REG_IDX_W'(i + 6);
            x[i] = 32'h2000 + 32'(i);
        end
        step(4'b1111, d, x, 1'b0);
        step(4'b1101, d, x, 1'b0);
        step(4'b1111, d, x, 1'b1);
        fu_valid = '0; #1;
        check("t5 ex_valid after flush", 64'(exv_w), 64'(0));
        check("t5 fu_ready after flush", 64'(fu_ready), 64'(4'b1111));

        // Randomized traffic with occasional flushes.
        pend_v = '0;
        for (int c = 0; c < 150; c++) rand_step(1'b1);

        // Test 6: asynchronous reset in the middle of a burst.
        for (int c = 0; c < 6; c++) rand_step(1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("t6 wb_en in rst", 64'(wb_en), 64'(0));
        check("t6 ex_valid in rst", 64'(exv_w), 64'(0));
        check("t6 fu_ready in rst", 64'(fu_ready), 64'(0));
        check("t6 wb_data0 in rst", 64'(wb_data[0]), 64'(0));
        fu_valid = '0;
        pend_v   = '0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        idle();
        for (int c = 0; c < 100; c++) rand_step(1'b1);
        repeat (4) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
